// File: rtl/seq_input_conditioner_pkg.sv
// Shared definitions for the sequence-detector input path: build-time defaults and the
// detector FSM state encodings, so the conditioner and the FSM agree on one source.
package seq_input_conditioner_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DB_CYCLES   = 1_000_000;
  localparam int DEF_TICK_DIV    = 268_435_456;

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  typedef enum logic [1:0] {
    ST_S0 = S0,
    ST_S1 = S1,
    ST_S2 = S2,
    ST_S3 = S3
  } fsm_state_e;

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_input_conditioner_db_cell.sv
// One conditioned input: a synchronizer chain followed by a persistence debouncer.
// The stable value only moves after DB_CYCLES consecutive cycles of disagreement.
module db_cell
  import seq_input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int            CW     = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_bit;
  logic [CW-1:0]          cnt_p1;

  // Stage p0: metastability chain, nothing but flops until the last stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync_bit = sync_p0[SYNC_STAGES-1];

  // Stage p1: any agreement restarts the persistence count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= 1'b0;
      cnt_p1 <= '0;
    end else if (sync_bit == stable) begin
      cnt_p1 <= '0;
    end else if (cnt_p1 == C_LAST) begin
      stable <= sync_bit;
      cnt_p1 <= '0;
    end else begin
      cnt_p1 <= cnt_p1 + C_ONE;
    end
  end

endmodule

// File: rtl/seq_input_conditioner.sv
// Front end of the serial sequence detector: debounced data bit plus a single-cycle
// advance strobe from either a manual button press or the periodic auto tick.
module seq_input_conditioner
  import seq_input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int TICK_DIV    = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  input  logic raw_step,
  input  logic raw_auto,
  output logic bit_out,
  output logic auto_mode,
  output logic step_pulse,
  output logic auto_tick,
  output logic step_en
);

  localparam int            TW     = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  logic          s_in;
  logic          s_step;
  logic          s_auto;
  logic          s_step_p1;
  logic          auto_mode_p1;
  logic [TW-1:0] tcnt_p1;

  db_cell #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_in (
    .clk    (clk),
    .reset  (reset),
    .raw    (raw_in),
    .stable (s_in)
  );

  db_cell #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_step (
    .clk    (clk),
    .reset  (reset),
    .raw    (raw_step),
    .stable (s_step)
  );

  db_cell #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_auto (
    .clk    (clk),
    .reset  (reset),
    .raw    (raw_auto),
    .stable (s_auto)
  );

  assign bit_out   = s_in;
  assign auto_mode = s_auto;

  // Stage p1: press edge detect and auto-step period counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_step_p1    <= 1'b0;
      step_pulse   <= 1'b0;
      auto_mode_p1 <= 1'b0;
      tcnt_p1      <= '0;
    end else begin
      s_step_p1    <= s_step;
      step_pulse   <= s_step & ~s_step_p1;
      auto_mode_p1 <= s_auto;
      // Count is held at 0 for the first auto cycle so the first tick lands a full period after the rise.
      if (!s_auto || !auto_mode_p1) begin
        tcnt_p1 <= '0;
      end else if (tcnt_p1 == T_LAST) begin
        tcnt_p1 <= '0;
      end else begin
        tcnt_p1 <= tcnt_p1 + T_ONE;
      end
    end
  end

  // Gating by auto_mode suppresses a tick in the cycle the mode drops.
  assign auto_tick = s_auto & (tcnt_p1 == T_LAST);
  assign step_en   = step_pulse | auto_tick;

endmodule
